// File: rtl/conv_bank_pkg.sv
// Shared types and helpers for the conv_bank_stream convolution bank.
// ReLU stage is enabled by defining CONV_BANK_RELU_EN.
package conv_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  function automatic int taps_f(input int n_in, input int fn);
    return n_in * fn * fn;
  endfunction

  function automatic int acc_w_f(input int width, input int taps);
    return 2 * width + $clog2(taps + 1) + 1;
  endfunction

  function automatic int addr_w_f(input int n_out, input int taps);
    return $clog2(n_out * (taps + 1));
  endfunction

  // A single-channel bank still needs a one-bit index port
  function automatic int ch_w_f(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_bank_stream_post.sv
// conv_post: fraction shift, optional ReLU and clip/wrap of one accumulator.
// ReLU is present only when CONV_BANK_RELU_EN is defined.
module conv_post
  import conv_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 22,
  parameter int FRAC  = 4
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             clip,
  input  logic             relu,
  input  logic [7:0]       relu_c,
  output logic [WIDTH-1:0] y
);

  logic signed [ACC_W-1:0] sh;
  logic signed [ACC_W-1:0] rl;

  always_comb begin
    sh = $signed(acc) >>> FRAC;
    rl = sh;
`ifdef CONV_BANK_RELU_EN
    if (relu && sh < ACC_W'($signed({1'b0, relu_c})))
      rl = '0;
`endif
    y = clip ? WIDTH'(saturate(64'(rl), WIDTH))
             : rl[WIDTH-1:0];
  end

`ifndef CONV_BANK_RELU_EN
  logic unused_cfg;
  assign unused_cfg = ^{relu, relu_c};
`endif

endmodule

// File: rtl/conv_bank_stream.sv
// Streaming multi-channel convolution bank: one window in, N_OUT outputs.
// Optional ReLU stage enabled by defining CONV_BANK_RELU_EN.
module conv_bank_stream
  import conv_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int FN    = 3,
  parameter int FRAC  = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic wr_en,
  input  logic [addr_w_f(N_OUT, taps_f(N_IN, FN))-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic [taps_f(N_IN, FN)*WIDTH-1:0] in_x,
  input  logic clip,
  input  logic relu,
  input  logic [7:0] relu_c,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [ch_w_f(N_OUT)-1:0] out_ch,
  output logic out_last
);

  localparam int TAPS  = taps_f(N_IN, FN);
  localparam int ACC_W = acc_w_f(WIDTH, TAPS);
  localparam int CH_W  = ch_w_f(N_OUT);
  localparam int NW    = N_OUT * TAPS;
  localparam int NCOEF = N_OUT * (TAPS + 1);

  state_t state;
  logic [CH_W-1:0] m;
  logic m_last;

  logic signed [WIDTH-1:0] coef [NCOEF];
  logic signed [WIDTH-1:0] x_lat [TAPS];
  logic clip_l;
  logic relu_l;
  logic [7:0] relu_c_l;

  logic signed [ACC_W-1:0] acc;
  logic [WIDTH-1:0] post_y;

  assign in_ready = (state == IDLE);
  assign m_last = (m == CH_W'(N_OUT - 1));

  // Coefficients may only change between windows
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCOEF; i++)
        coef[i] <= '0;
    end else if (state == IDLE && wr_en
                 && int'(wr_addr) < NCOEF) begin
      coef[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    acc = ACC_W'(coef[NW + int'(m)]) <<< FRAC;
    for (int t = 0; t < TAPS; t++)
      acc = acc
          + ACC_W'(coef[int'(m) * TAPS + t])
          * ACC_W'(x_lat[t]);
  end

  conv_post #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_post (
    .acc    (acc),
    .clip   (clip_l),
    .relu   (relu_l),
    .relu_c (relu_c_l),
    .y      (post_y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      m         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      clip_l    <= 1'b0;
      relu_l    <= 1'b0;
      relu_c_l  <= '0;
      for (int t = 0; t < TAPS; t++)
        x_lat[t] <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            for (int t = 0; t < TAPS; t++)
              x_lat[t] <= in_x[t*WIDTH +: WIDTH];
            clip_l   <= clip;
            relu_l   <= relu;
            relu_c_l <= relu_c;
            m        <= '0;
            state    <= CALC;
          end
        end
        state == CALC: begin
          out_data  <= post_y;
          out_ch    <= m;
          out_last  <= m_last;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        state == HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (m_last) begin
              state <= IDLE;
            end else begin
              m     <= m + 1'b1;
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bank_stream.sv
// Self-checking bench for conv_bank_stream (default parameters).
// Expectations follow CONV_BANK_RELU_EN when it is defined.
module tb_conv_bank_stream;

  localparam int W  = 8;
  localparam int NI = 2;
  localparam int NO = 4;
  localparam int F  = 3;
  localparam int FR = 4;
  localparam int TP = NI * F * F;
  localparam int NC = NO * (TP + 1);

  logic clk;
  logic resetn;
  logic wr_en;
  logic [6:0] wr_addr;
  logic [W-1:0] wr_data;
  logic in_valid;
  logic in_ready;
  logic [TP*W-1:0] in_x;
  logic clip;
  logic relu;
  logic [7:0] relu_c;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [1:0] out_ch;
  logic out_last;

  int checks = 0;
  int errors = 0;

  conv_bank_stream #(
    .WIDTH (W),
    .N_IN  (NI),
    .N_OUT (NO),
    .FN    (F),
    .FRAC  (FR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .clip      (clip),
    .relu      (relu),
    .relu_c    (relu_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int data;
    int ch;
    int last;
  } exp_t;

  int wm [NO][TP];
  int bm [NO];
  exp_t q[$];

  function automatic int model(input int mch, input logic [TP*W-1:0] x,
                               input logic cl, input logic rl,
                               input logic [7:0] rc);
    int acc;
    int s;
    logic [31:0] sv;
    acc = bm[mch] * (1 << FR);
    for (int t = 0; t < TP; t++)
      acc += wm[mch][t] * int'($signed(x[t*W +: W]));
    s = acc >>> FR;
`ifdef CONV_BANK_RELU_EN
    if (rl && s < int'(rc)) s = 0;
`endif
    if (cl) begin
      if (s > 127) s = 127;
      if (s < -128) s = -128;
    end else begin
      sv = s;
      s = int'($signed(sv[7:0]));
    end
    return s;
  endfunction

  // Inputs change just after posedge, so negedge sees next-edge values
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      for (int a = 0; a < NO; a++) begin
        bm[a] = 0;
        for (int t = 0; t < TP; t++) wm[a][t] = 0;
      end
    end else begin
      chk("in_ready", int'(in_ready), int'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("out_data", int'($signed(out_data)), q[0].data);
          chk("out_ch", int'(out_ch), q[0].ch);
          chk("out_last", int'(out_last), q[0].last);
        end
      end
      if (wr_en && in_ready && int'(wr_addr) < NC) begin
        if (int'(wr_addr) < NO * TP)
          wm[int'(wr_addr) / TP][int'(wr_addr) % TP] =
            int'($signed(wr_data));
        else
          bm[int'(wr_addr) - NO * TP] = int'($signed(wr_data));
      end
      if (in_valid && in_ready) begin
        for (int c = 0; c < NO; c++) begin
          exp_t e;
          e.data = model(c, in_x, clip, relu, relu_c);
          e.ch = c;
          e.last = int'(c == NO - 1);
          q.push_back(e);
        end
      end
      if (out_valid && out_ready && q.size() > 0)
        void'(q.pop_front());
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 7'(a);
    wr_data = W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (in_ready) break;
      tick();
    end
    if (i == 200) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [TP*W-1:0] x, input logic cl,
                      input logic rl, input logic [7:0] rc);
    wait_idle();
    in_x = x;
    clip = cl;
    relu = rl;
    relu_c = rc;
    in_valid = 1'b1;
    tick();
    // Scramble config after acceptance; it must not matter
    in_valid = 1'b0;
    in_x = ~x;
    clip = ~cl;
    relu = ~rl;
    relu_c = ~rc;
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
    end
    if (i == 50) chk("valid_timeout", 0, 1);
  endtask

  task automatic first_out(output int v);
    wait_valid();
    v = int'($signed(out_data));
  endtask

  task automatic drain();
    int i;
    out_ready = 1'b1;
    for (i = 0; i < 200; i++) begin
      if (in_ready && !out_valid) break;
      tick();
    end
    if (i == 200) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [TP*W-1:0] centre(input int v);
    logic [TP*W-1:0] x;
    x = '0;
    x[4*W +: W] = W'(v);
    return x;
  endfunction

  function automatic logic [TP*W-1:0] fill(input int v);
    logic [TP*W-1:0] x;
    for (int t = 0; t < TP; t++) x[t*W +: W] = W'(v);
    return x;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v;
    logic [TP*W-1:0] xb;
    resetn = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    in_valid = 1'b0;
    in_x = '0;
    clip = 1'b0;
    relu = 1'b0;
    relu_c = '0;
    out_ready = 1'b0;
    #23;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    tick();
    resetn = 1'b1;
    tick();
    chk("rel_in_ready", int'(in_ready), 1);

    // Identity tap (16 = 1.0 with 4 fraction bits) and latency
    wr(4, 16);
    send(centre(5), 1'b1, 1'b0, 8'd0);
    chk("lat_first_edge", int'(out_valid), 0);
    tick();
    chk("lat_second_edge", int'(out_valid), 1);
    chk("id_data", int'($signed(out_data)), 5);
    chk("id_ch", int'(out_ch), 0);
    chk("id_last", int'(out_last), 0);
    // Write while busy must be dropped
    wr(4, 32);
    drain();
    out_ready = 1'b0;
    send(centre(5), 1'b1, 1'b0, 8'd0);
    first_out(v);
    chk("busy_wr_next", v, 5);
    drain();
    wr(4, 32);
    wr(100, 77);
    out_ready = 1'b0;
    send(centre(5), 1'b1, 1'b0, 8'd0);
    first_out(v);
    chk("idle_wr_used", v, 10);
    drain();

    // Saturation versus wrap
    for (int t = 0; t < TP; t++) wr(t, 127);
    out_ready = 1'b0;
    send(fill(127), 1'b1, 1'b0, 8'd0);
    first_out(v);
    chk("sat_pos_clip", v, 127);
    drain();
    out_ready = 1'b0;
    send(fill(127), 1'b0, 1'b0, 8'd0);
    first_out(v);
    chk("sat_pos_wrap", v, -31);
    drain();
    out_ready = 1'b0;
    send(fill(-128), 1'b1, 1'b0, 8'd0);
    first_out(v);
    chk("sat_neg_clip", v, -128);
    drain();
    out_ready = 1'b0;
    send(fill(-128), 1'b0, 1'b0, 8'd0);
    first_out(v);
    chk("sat_neg_wrap", v, -112);

    // Reset in the middle of HOLD
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_data", int'(out_data), 0);

    // ReLU behaviour
    wr(4, 16);
    send(centre(-3), 1'b1, 1'b1, 8'd0);
    first_out(v);
`ifdef CONV_BANK_RELU_EN
    chk("relu_neg", v, 0);
`else
    chk("relu_neg", v, -3);
`endif
    drain();
    out_ready = 1'b0;
    send(centre(4), 1'b1, 1'b1, 8'd5);
    first_out(v);
`ifdef CONV_BANK_RELU_EN
    chk("relu_below_c", v, 0);
`else
    chk("relu_below_c", v, 4);
`endif
    drain();
    out_ready = 1'b0;
    send(centre(6), 1'b1, 1'b1, 8'd5);
    first_out(v);
    chk("relu_above_c", v, 6);
    drain();

    // Mixed weights, biases and backpressure on all channels
    do_reset();
    for (int a = 0; a < NO * TP; a++)
      wr(a, ((a * 7 + (a % TP) * 3) % 11) - 5);
    for (int c = 0; c < NO; c++) wr(NO * TP + c, c * 3 - 4);
    for (int t = 0; t < TP; t++) xb[t*W +: W] = W'((t * 13) % 40 - 20);
    out_ready = 1'b0;
    send(xb, 1'b1, 1'b0, 8'd0);
    for (int c = 0; c < NO; c++) begin
      wait_valid();
      repeat (5) begin
        chk("bp_ready_low", int'(in_ready), 0);
        chk("bp_ch", int'(out_ch), c);
        chk("bp_last", int'(out_last), int'(c == NO - 1));
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("bp_idle_after", int'(in_ready), 1);
    send(xb, 1'b0, 1'b0, 8'd0);
    drain();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
